// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the ALU writeback stage.
// Pure declarations: no latency or backpressure of its own.
package alu_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int ADDR_W_DEF = 4;
    localparam int SHAMT_W    = 5;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_OR     = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SHL    = 4'd6;
    localparam logic [3:0] OP_SHR    = 4'd7;
    localparam logic [3:0] OP_PASS_B = 4'd8;
    localparam logic [3:0] OP_MUL    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier, low DATA_W bits of a*b, one partial product per cycle.
// Latency DATA_W cycles after start; done/product valid combinationally on the last step, no backpressure.
module shift_add_multiplier #(
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_run;

    logic [DATA_W-1:0] w_partial;
    logic [DATA_W-1:0] w_acc_next;

    assign w_partial  = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_partial;

    // Product includes the step happening this cycle so the caller can latch it on the done edge.
    assign done    = r_run && (r_cnt == CNT_W'(DATA_W - 1));
    assign product = w_acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (start) begin
            r_mcand  <= multiplicand;
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU execute stage driving the register-file write port; SAT_ARITH_EN selects saturating signed ADD/SUB.
// Latency 1 cycle (MUL: DATA_W+1); in_ready drops only while a multiply is in flight or in reset.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] dest_reg,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_ovf,
    output logic              busy
);

    localparam int MSB = DATA_W - 1;

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;
    logic              r_zero;
    logic              r_carry;
    logic              r_ovf;
    logic              r_busy;
    logic [ADDR_W-1:0] r_mul_dest;

    logic              w_accept;
    logic              w_is_nop;
    logic              w_is_mul;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;
    logic [DATA_W:0]   w_shl;
    logic [DATA_W:0]   w_shr_ext;
    logic [SHAMT_W-1:0] w_shamt;
    logic              w_sh_big;
    logic              w_add_ovf;
    logic              w_sub_ovf;
    logic [DATA_W-1:0] w_res;
    logic              w_carry;
    logic              w_ovf;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_product;

    assign in_ready = rst_n && (r_state != ST_MUL);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (opcode == OP_MUL);
    assign w_is_nop = (opcode == OP_NOP) || (opcode > OP_MUL);

    assign w_add     = {1'b0, operand_a} + {1'b0, operand_b};
    assign w_sub     = {1'b0, operand_a} - {1'b0, operand_b};
    assign w_add_ovf = (operand_a[MSB] == operand_b[MSB]) && (w_add[MSB] != operand_a[MSB]);
    assign w_sub_ovf = (operand_a[MSB] != operand_b[MSB]) && (w_sub[MSB] != operand_a[MSB]);

    // The extra bit on each shift catches the last bit shifted out, which becomes carry.
    assign w_shamt   = operand_b[SHAMT_W-1:0];
    assign w_sh_big  = int'(w_shamt) >= DATA_W;
    assign w_shl     = {1'b0, operand_a} << w_shamt;
    assign w_shr_ext = {operand_a, 1'b0} >> w_shamt;

    function automatic logic [DATA_W-1:0] sat_value(input logic a_neg);
        return a_neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_res   = w_add[DATA_W-1:0];
                w_carry = w_add[DATA_W];
                w_ovf   = w_add_ovf;
`ifdef SAT_ARITH_EN
                if (w_add_ovf) w_res = sat_value(operand_a[MSB]);
`endif
            end
            OP_SUB: begin
                w_res   = w_sub[DATA_W-1:0];
                w_carry = w_sub[DATA_W];
                w_ovf   = w_sub_ovf;
`ifdef SAT_ARITH_EN
                if (w_sub_ovf) w_res = sat_value(operand_a[MSB]);
`endif
            end
            OP_AND:    w_res = operand_a & operand_b;
            OP_OR:     w_res = operand_a | operand_b;
            OP_XOR:    w_res = operand_a ^ operand_b;
            OP_SHL: begin
                if (!w_sh_big) begin
                    w_res   = w_shl[DATA_W-1:0];
                    w_carry = w_shl[DATA_W];
                end
            end
            OP_SHR: begin
                if (!w_sh_big) begin
                    w_res   = w_shr_ext[DATA_W:1];
                    w_carry = w_shr_ext[0];
                end
            end
            OP_PASS_B: w_res = operand_b;
            default:   ;
        endcase
    end

    shift_add_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (w_accept && w_is_mul),
        .multiplicand (operand_a),
        .multiplier   (operand_b),
        .done         (w_mul_done),
        .product      (w_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_mul_dest <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WB: begin
                    if (w_accept && w_is_mul) begin
                        r_state    <= ST_MUL;
                        r_busy     <= 1'b1;
                        r_mul_dest <= dest_reg;
                    end else if (w_accept && !w_is_nop) begin
                        r_state <= ST_WB;
                        r_we    <= 1'b1;
                        r_wreg  <= dest_reg;
                        r_wdata <= w_res;
                        r_zero  <= (w_res == '0);
                        r_carry <= w_carry;
                        r_ovf   <= w_ovf;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    // Write-back register and flags stay untouched until the product is final.
                    if (w_mul_done) begin
                        r_state <= ST_WB;
                        r_busy  <= 1'b0;
                        r_we    <= 1'b1;
                        r_wreg  <= r_mul_dest;
                        r_wdata <= w_product;
                        r_zero  <= (w_product == '0);
                        r_carry <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign write_enable   = r_we;
    assign write_register = r_wreg;
    assign write_data     = r_wdata;
    assign flag_zero      = r_zero;
    assign flag_carry     = r_carry;
    assign flag_ovf       = r_ovf;
    assign busy           = r_busy;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: a driver pushes model-predicted writes, a negedge monitor pops and compares.
module tb_alu_writeback_stage;

    localparam int     DW     = 20;
    localparam int     AW     = 4;
    localparam longint PERIOD = 10;
    localparam longint MASK   = 64'h000F_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [AW-1:0] dest_reg;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic          write_enable;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;
    logic          flag_zero;
    logic          flag_carry;
    logic          flag_ovf;
    logic          busy;

    alu_writeback_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .opcode         (opcode),
        .dest_reg       (dest_reg),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .write_enable   (write_enable),
        .write_register (write_register),
        .write_data     (write_data),
        .flag_zero      (flag_zero),
        .flag_carry     (flag_carry),
        .flag_ovf       (flag_ovf),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rg;
        logic [DW-1:0] d;
        logic          z;
        logic          c;
        logic          v;
        longint        t;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    bit     mon_en = 0;
    bit     mul_pending = 0;
    longint mul_acc_t = 0;

    // Last value the register-file port and flags must hold between writes.
    logic [AW-1:0] hold_reg  = '0;
    logic [DW-1:0] hold_data = '0;
    logic          hold_z = 0, hold_c = 0, hold_v = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit busy_exp(input longint t);
        return mul_pending && (t > mul_acc_t) && (t < mul_acc_t + DW * PERIOD);
    endfunction

    function automatic longint to_signed(input int x);
        return (x >= 'h80000) ? longint'(x) - 64'sh100000 : longint'(x);
    endfunction

    function automatic exp_t model(input int op, input int a, input int b, input int dest);
        exp_t   e;
        longint r = 0;
        longint s = 0;
        int     sh = b & 31;
        e.rg = 4'(dest);
        e.c  = 1'b0;
        e.v  = 1'b0;
        e.t  = 0;
        case (op)
            1: begin
                r   = longint'(a) + longint'(b);
                e.c = (r >= 64'h100000);
                s   = to_signed(a) + to_signed(b);
                e.v = (s > 64'sh7FFFF) || (s < -64'sh80000);
            end
            2: begin
                r   = longint'(a) - longint'(b);
                e.c = (a < b);
                s   = to_signed(a) - to_signed(b);
                e.v = (s > 64'sh7FFFF) || (s < -64'sh80000);
            end
            3: r = longint'(a & b);
            4: r = longint'(a | b);
            5: r = longint'(a ^ b);
            6: if (sh < DW) begin
                r = longint'(a) << sh;
                if (sh > 0) e.c = ((a >> (DW - sh)) & 1) != 0;
            end
            7: if (sh < DW) begin
                r = longint'(a >> sh);
                if (sh > 0) e.c = ((a >> (sh - 1)) & 1) != 0;
            end
            8: r = longint'(b);
            9: r = longint'(a) * longint'(b);
            default: r = 0;
        endcase
        r = r & MASK;
`ifdef SAT_ARITH_EN
        if ((op == 1 || op == 2) && e.v) r = (s > 0) ? 64'h7FFFF : 64'h80000;
`endif
        e.d = DW'(r);
        e.z = (r == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (write_enable) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: reg %0d data 0x%0h with no pending result at t=%0t",
                             write_register, write_data, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_time",  $time,          e.t);
                    chk("wr_reg",   write_register, e.rg);
                    chk("wr_data",  write_data,     e.d);
                    chk("wr_zero",  flag_zero,      e.z);
                    chk("wr_carry", flag_carry,     e.c);
                    chk("wr_ovf",   flag_ovf,       e.v);
                    hold_reg  = e.rg;
                    hold_data = e.d;
                    hold_z    = e.z;
                    hold_c    = e.c;
                    hold_v    = e.v;
                end
            end else begin
                chk("hold_reg",   write_register, hold_reg);
                chk("hold_data",  write_data,     hold_data);
                chk("hold_zero",  flag_zero,      hold_z);
                chk("hold_carry", flag_carry,     hold_c);
                chk("hold_ovf",   flag_ovf,       hold_v);
            end
            chk("busy", busy, busy_exp($time));
        end
    end

    task automatic issue(input int op, input int a, input int b, input int dest);
        bit acc   = 0;
        int tries = 0;
        while (!acc) begin
            @(negedge clk);
            #2;
            in_valid  = 1'b1;
            opcode    = 4'(op);
            operand_a = DW'(a);
            operand_b = DW'(b);
            dest_reg  = AW'(dest);
            #1;
            chk("in_ready", in_ready, rst_n && !busy_exp($time));
            acc = in_ready;
            if (acc) begin
                longint e_t = $time + 2;
                if (op == 9) begin
                    mul_pending = 1;
                    mul_acc_t   = e_t;
                end
                if (op >= 1 && op <= 9) begin
                    exp_t e;
                    e   = model(op, a, b, dest);
                    e.t = e_t + PERIOD / 2 + ((op == 9) ? DW * PERIOD : 0);
                    sb.push_back(e);
                end
            end else if (++tries > 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: op %0d never accepted", op);
                acc = 1;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        #1;
        chk("in_ready_idle", in_ready, rst_n && !busy_exp($time));
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
            rst_n     = 1'b0;
            in_valid  = 1'b1;
            opcode    = 4'($urandom_range(1, 9));
            operand_a = DW'($urandom);
            operand_b = DW'($urandom);
            dest_reg  = AW'($urandom);
            sb.delete();
            mul_pending = 0;
            hold_reg  = '0;
            hold_data = '0;
            hold_z = 0; hold_c = 0; hold_v = 0;
            #1;
            chk("in_ready_rst", in_ready, 0);
            mon_en = 1;
        end
        @(negedge clk);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("in_ready_rel", in_ready, 1);
    endtask

    function automatic int rnd_val();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 'h7FFFF;
            2:       return 'h80000;
            3:       return 'hFFFFF;
            4:       return int'($urandom_range(0, 31));
            default: return int'($urandom_range(0, 'hFFFFF));
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        dest_reg  = '0;
        operand_a = '0;
        operand_b = '0;
        do_reset(3);

        issue(1, 'h7FFFF, 'h00001, 5);
        issue(2, 'h00003, 'h00005, 2);
        issue(5, 'h12345, 'h12345, 7);
        idle();

        for (int i = 1; i <= 4; i++) issue(1, rnd_val(), rnd_val(), i);
        idle();

        issue(9, 'h00123, 'h00045, 9);
        issue(1, 'h00010, 'h00020, 10);
        issue(0, 'h11111, 'h22222, 11);
        issue(12, 'h11111, 'h22222, 12);
        idle();

        issue(6, 'h80001, 20, 0);
        issue(6, 'h80001, 1, 1);
        issue(6, 'h12345, 0, 2);
        issue(7, 'h00003, 1, 3);
        issue(7, 'hFFFFF, 31, 4);
        issue(8, 'h0, 'hABCDE, 6);
        idle();

        issue(1, 'h00001, 'h00002, 8);
        do_reset(3);
        idle();

        issue(9, 'h00321, 'h00007, 13);
        repeat (9) idle();
        do_reset(1);
        issue(1, 'h00004, 'h00005, 14);
        idle();

        for (int i = 0; i < 200; i++) begin
            int op = int'($urandom_range(0, 15));
            if (op == 9 && $urandom_range(0, 3) != 0) op = 1;
            if ($urandom_range(0, 4) == 0) idle();
            if (i == 120) do_reset(2);
            issue(op, rnd_val(), rnd_val(), int'($urandom_range(0, 15)));
        end
        repeat (30) idle();
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
